// File: rtl/conv_pkg.sv
// Shared constants for the conv core output path: layer geometry, ofmap
// width, output word addressing and the writeback FSM state encoding.
package conv_pkg;

  localparam int OFM_W         = 25;
  localparam int H_OUT         = 61;
  localparam int W_OUT         = 61;
  localparam int WORDS_PER_ROW = 16;
  localparam int CH_PER_GROUP  = 8;
  localparam int ADDR_W        = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ofm_requant.sv
// Combinational requantiser: ReLU on the signed conv result, round-half-up
// right shift, then clamp to an unsigned byte.
module ofm_requant
  import conv_pkg::*;
(
  input  logic signed [OFM_W-1:0] ofmap_i,
  input  logic [4:0]              shift_i,
  output logic [7:0]              q_o
);

  // One guard bit above the ofmap width keeps the rounding add from wrapping.
  function automatic logic [OFM_W:0] round_shift(input logic [OFM_W:0] v,
                                                 input logic [4:0]   sh);
    logic [OFM_W:0] bias;
    bias = '0;
    if (sh != 5'd0) begin
      bias = {{OFM_W{1'b0}}, 1'b1} << (sh - 5'd1);
    end
    return (v + bias) >> sh;
  endfunction

  function automatic logic [7:0] sat255(input logic [OFM_W:0] r);
    return (r > (OFM_W+1)'(255)) ? 8'hFF : r[7:0];
  endfunction

  logic [OFM_W:0] relu_v;

  // ReLU, round and saturate in one combinational cone.
  always_comb begin
    relu_v = ofmap_i[OFM_W-1] ? '0 : {1'b0, ofmap_i};
    q_o    = sat255(round_shift(relu_v, shift_i));
  end

endmodule

// File: rtl/ofm_writeback.sv
// Output writeback for the conv core: requantises each ofmap result, packs
// four columns per 32-bit word, writes raster-addressed words to the output
// SRAM and flags completion of the layer.
module ofm_writeback
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_conv,
  input  logic [1:0]              cfg_co,
  input  logic [4:0]              shift,
  input  logic                    in_valid,
  input  logic signed [OFM_W-1:0] ofmap,
  output logic                    out_wr_en,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [31:0]             out_wdata,
  output logic [3:0]              out_byte_en,
  output logic                    done,
  output logic                    err_extra
);

  // Valid byte lanes of the short word that closes a row.
  function automatic logic [3:0] lane_mask(input logic [1:0] l);
    logic [3:0] m;
    case (l)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  logic                start_q, start_rise;
  logic [1:0]          state_q, state_d;
  logic [1:0]          co_q, co_sel;
  logic                fin_q, fin_d;
  logic [5:0]          col_q, col_d, row_q, row_d, pos_col, pos_row;
  logic [4:0]          ch_q, ch_d, pos_ch, ch_max;
  logic                accept, is_last;
  logic [7:0]          q_s0;

  logic                vld_p1, last_p1;
  logic [7:0]          q_p1;
  logic [5:0]          col_p1, row_p1;
  logic [4:0]          ch_p1;

  logic                wr_fire, word_end;
  logic [1:0]          lane;
  logic [31:0]         word, pack_q, pack_d;
  logic [ADDR_W-1:0]   row_idx, addr_s2;
  logic [3:0]          be_s2;

  logic                out_wr_en_q, err_q, err_d;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [31:0]         out_wdata_q;
  logic [3:0]          out_be_q;

  // ---- stage 0: edge detect, position counters, requant ----
  assign start_rise = start_conv & ~start_q;
  assign co_sel     = start_rise ? cfg_co : co_q;
  assign ch_max     = 5'((32'(co_sel) + 1) * CH_PER_GROUP - 1);
  assign pos_col    = start_rise ? '0 : col_q;
  assign pos_row    = start_rise ? '0 : row_q;
  assign pos_ch     = start_rise ? '0 : ch_q;
  assign accept     = in_valid & (start_rise | ((state_q == ST_RUN) & ~fin_q));
  assign is_last    = (pos_col == 6'(W_OUT-1)) & (pos_row == 6'(H_OUT-1)) & (pos_ch == ch_max);

  ofm_requant u_requant (
    .ofmap_i (ofmap),
    .shift_i (shift),
    .q_o     (q_s0)
  );

  // Raster advance: col fastest, then row, then channel; a new layer restarts at 0.
  always_comb begin
    col_d = pos_col;
    row_d = pos_row;
    ch_d  = pos_ch;
    fin_d = start_rise ? 1'b0 : fin_q;
    if (accept) begin
      fin_d = fin_d | is_last;
      if (pos_col == 6'(W_OUT-1)) begin
        col_d = '0;
        if (pos_row == 6'(H_OUT-1)) begin
          row_d = '0;
          ch_d  = pos_ch + 5'd1;
        end else begin
          row_d = pos_row + 6'd1;
        end
      end else begin
        col_d = pos_col + 6'd1;
      end
    end
  end

  // ---- stage 1: registered byte and its raster position ----
  // Byte and position carry no reset; vld_p1 qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_p1    <= q_s0;
      col_p1  <= pos_col;
      row_p1  <= pos_row;
      ch_p1   <= pos_ch;
      last_p1 <= is_last;
    end
  end

  // ---- stage 2: pack into lane, address, FSM ----
  // A restart edge drops any result still in flight from the old layer.
  assign wr_fire  = vld_p1 & ~start_rise;
  assign lane     = col_p1[1:0];
  assign word_end = (lane == 2'd3) | (col_p1 == 6'(W_OUT-1));
  assign row_idx  = ADDR_W'(ch_p1) * ADDR_W'(H_OUT) + ADDR_W'(row_p1);
  assign addr_s2  = row_idx * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(col_p1[5:2]);
  assign be_s2    = (col_p1 == 6'(W_OUT-1)) ? lane_mask(lane) : 4'b1111;

  // Merge the new byte into the partial word; clear after a write or restart.
  always_comb begin
    word            = pack_q;
    word[8*lane +: 8] = q_p1;
    pack_d          = pack_q;
    if (start_rise) begin
      pack_d = '0;
    end else if (wr_fire) begin
      pack_d = word_end ? '0 : word;
    end
  end

  // FSM and sticky error next-state.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (start_rise) begin
      state_d = ST_RUN;
      err_d   = 1'b0;
    end else begin
      if ((state_q == ST_RUN) && wr_fire && last_p1) begin
        state_d = ST_DONE;
      end
      if ((state_q == ST_DONE) && in_valid) begin
        err_d = 1'b1;
      end
    end
  end

  // Control state, counters, pack buffer and registered SRAM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      state_q     <= ST_IDLE;
      co_q        <= '0;
      fin_q       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      vld_p1      <= 1'b0;
      pack_q      <= '0;
      err_q       <= 1'b0;
      out_wr_en_q <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      out_be_q    <= '0;
    end else begin
      start_q     <= start_conv;
      state_q     <= state_d;
      co_q        <= co_sel;
      fin_q       <= fin_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      vld_p1      <= accept;
      pack_q      <= pack_d;
      err_q       <= err_d;
      out_wr_en_q <= wr_fire & word_end;
      if (wr_fire && word_end) begin
        out_addr_q  <= addr_s2;
        out_wdata_q <= word;
        out_be_q    <= be_s2;
      end
    end
  end

  assign out_wr_en   = out_wr_en_q;
  assign out_addr    = out_addr_q;
  assign out_wdata   = out_wdata_q;
  assign out_byte_en = out_be_q;
  assign done        = (state_q == ST_DONE);
  assign err_extra   = err_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// Randomised self-checking bench for ofm_writeback with a raster-index
// reference model and an expected-write scoreboard.
module tb_ofm_writeback;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_conv;
  logic [1:0]         cfg_co;
  logic [4:0]         shift;
  logic               in_valid;
  logic signed [24:0] ofmap;
  logic               out_wr_en;
  logic [14:0]        out_addr;
  logic [31:0]        out_wdata;
  logic [3:0]         out_byte_en;
  logic               done;
  logic               err_extra;

  ofm_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_conv  (start_conv),
    .cfg_co      (cfg_co),
    .shift       (shift),
    .in_valid    (in_valid),
    .ofmap       (ofmap),
    .out_wr_en   (out_wr_en),
    .out_addr    (out_addr),
    .out_wdata   (out_wdata),
    .out_byte_en (out_byte_en),
    .done        (done),
    .err_extra   (err_extra)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [14:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          last;
  } wr_t;

  wr_t        exq[$];
  int         m_n = 0, m_total = 0, m_state = 0, m_nw = 0;
  bit         m_sprev = 0, m_err = 0;
  logic [7:0] m_bytes[4];

  function automatic int mq(input int x, input int s);
    longint v;
    v = (x < 0) ? 0 : x;
    if (s > 0) v = (v + (longint'(1) << (s - 1))) >> s;
    return (v > 255) ? 255 : int'(v);
  endfunction

  task automatic model_step(input bit sv, input bit iv, input int val);
    bit  rise;
    int  col, row, ch;
    wr_t e;
    rise    = sv && !m_sprev;
    m_sprev = sv;
    if (rise) begin
      m_n = 0; m_nw = 0; m_state = 1; m_err = 0;
      m_total = 61 * 61 * (int'(cfg_co) + 1) * 8;
      for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
      while (exq.size() > 0 && exq[$].due >= cyc + 1) void'(exq.pop_back());
    end else if (iv && m_state == 2) begin
      m_err = 1;
    end
    if (iv && m_state == 1 && m_n < m_total) begin
      col = m_n % 61;
      row = (m_n / 61) % 61;
      ch  = m_n / (61 * 61);
      m_bytes[col % 4] = 8'(mq(val, int'(shift)));
      if (col % 4 == 3 || col == 60) begin
        e.due  = cyc + 2;
        e.addr = 15'((ch * 61 + row) * 16 + col / 4);
        e.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        e.be   = (col == 60) ? 4'b0001 : 4'b1111;
        e.last = (m_n == m_total - 1);
        exq.push_back(e);
        m_nw++;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
      end
      m_n++;
      if (m_n == m_total) m_state = 2;
    end
  endtask

  // ---------------- write monitor ----------------
  int          n_wr = 0;
  logic [31:0] cap0, cap15, cap16, last_wdata;
  logic [3:0]  capbe15, capbe16;

  always @(negedge clk) begin
    while (exq.size() > 0 && exq[0].due < cyc) begin
      chk("missing_wr", 1'b0, 1'b1);
      void'(exq.pop_front());
    end
    if (exq.size() > 0 && exq[0].due == cyc) begin
      wr_t e;
      e = exq.pop_front();
      chk("wr_en", out_wr_en, 1'b1);
      chk("addr", out_addr, e.addr);
      chk("wdata", out_wdata, e.data);
      chk("byte_en", out_byte_en, e.be);
      chk("done_at_wr", done, e.last);
      n_wr++;
      last_wdata = out_wdata;
      if (out_addr == 15'd0)  cap0 = out_wdata;
      if (out_addr == 15'd15) begin cap15 = out_wdata; capbe15 = out_byte_en; end
      if (out_addr == 15'd16) begin cap16 = out_wdata; capbe16 = out_byte_en; end
    end else if (out_wr_en) begin
      chk("unexpected_wr", out_wr_en, 1'b0);
    end
  end

  always @(posedge clk) begin
    if (cyc > 95000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
      $fatal(1, "watchdog");
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit sv, input bit iv, input int val);
    logic signed [24:0] d;
    d          = 25'(val);
    start_conv = sv;
    in_valid   = iv;
    ofmap      = d;
    model_step(sv, iv, int'(d));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, int'($urandom));
  endtask

  function automatic int rnd_val(input int sh);
    int k;
    k = int'($urandom_range(0, 3));
    if (k == 0) return int'($urandom);
    if (k == 1) return int'($urandom_range(0, 4000)) - 1000;
    if (k == 2) return (int'($urandom_range(0, 300)) << sh) + int'($urandom_range(0, 2)) - 1;
    return (int'($urandom_range(0, 255)) << sh) + ((sh > 0) ? (1 << (sh - 1)) : 0);
  endfunction

  initial begin
    int wr0;
    rst_n = 1'b0; start_conv = 1'b0; cfg_co = 2'd0; shift = 5'd0;
    in_valid = 1'b0; ofmap = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", out_wr_en, 1'b0);
    chk("rst_addr", out_addr, 15'd0);
    chk("rst_wdata", out_wdata, 32'd0);
    chk("rst_be", out_byte_en, 4'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_extra, 1'b0);
    rst_n = 1'b1;
    idle(2);
    // in_valid while idle must be ignored
    for (int i = 0; i < 5; i++) drive(0, 1, i * 40);
    idle(3);

    // Rounding word, then an abandoned partial word.
    cfg_co = 2'd0; shift = 5'd4;
    drive(1, 1, -5);
    drive(1, 1, 15);
    drive(0, 1, 16);
    drive(0, 1, 32'h1FFFFF);
    idle(3);
    chk("round_word", last_wdata, 32'hFF010100);
    drive(0, 1, 1000);
    drive(0, 1, 2000);
    idle(4);

    // Full layer, col+row data, dense at first then occasional gaps.
    shift = 5'd0;
    wr0 = n_wr;
    for (int n = 0; n < 61 * 61 * 8; n++) begin
      if (n > 200 && $urandom_range(0, 7) == 0) drive(0, 0, int'($urandom));
      drive(n == 0, 1, (n % 61) + ((n / 61) % 61));
    end
    idle(4);
    chk("layer_writes", n_wr - wr0, 16 * 61 * 8);
    chk("model_writes", m_nw, 16 * 61 * 8);
    chk("addr0_word", cap0, 32'h03020100);
    chk("addr15_word", cap15, 32'h0000003C);
    chk("addr15_be", capbe15, 4'b0001);
    chk("addr16_word", cap16, 32'h04030201);
    chk("addr16_be", capbe16, 4'b1111);
    chk("done_hold", done, 1'b1);
    chk("err_before", err_extra, 1'b0);

    // Extra results after done.
    for (int i = 0; i < 3; i++) drive(0, 1, 77);
    chk("err_set", err_extra, m_err);
    chk("done_after_extra", done, 1'b1);
    idle(2);

    // Random layer: random shift and data, start with a coincident result.
    cfg_co = 2'($urandom_range(0, 3));
    shift  = 5'($urandom_range(0, 24));
    drive(1, 1, rnd_val(int'(shift)));
    chk("err_cleared", err_extra, 1'b0);
    chk("done_cleared", done, 1'b0);
    for (int n = 1; n < 3002; n++) begin
      if ($urandom_range(0, 3) == 0) drive(0, 0, int'($urandom));
      drive(0, 1, rnd_val(int'(shift)));
    end
    drive(0, 1, rnd_val(int'(shift)));

    // Asynchronous reset in the middle of a word.
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", out_wr_en, 1'b0);
    chk("arst_addr", out_addr, 15'd0);
    chk("arst_wdata", out_wdata, 32'd0);
    chk("arst_be", out_byte_en, 4'd0);
    chk("arst_done", done, 1'b0);
    exq.delete();
    m_state = 0; m_sprev = 0; m_err = 0;
    in_valid = 1'b0; start_conv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) drive(0, 1, 255);
    idle(4);
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_err", err_extra, 1'b0);
    chk("post_rst_pending", exq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
